// File: rtl/control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Types and defaults for the flush / redirect sequencer.
//   FLUSH_CYCLES_DEF / SYNC_TIMEOUT_DEF : default parameter values
//   FLUSH_CNT_W / SYNC_CNT_W            : timer widths covering the legal ranges
//   flush_state_e                       : sequencer state encoding
//   flush_req_e                         : kind of request being sequenced
// -----------------------------------------------------------------------------
package control_pkg;

    localparam int unsigned FLUSH_CYCLES_DEF = 2;
    localparam int unsigned SYNC_TIMEOUT_DEF = 64;

    // 1..15 and 1..1023 are loaded as (value - 1)
    localparam int unsigned FLUSH_CNT_W = 4;
    localparam int unsigned SYNC_CNT_W  = 10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ABORT    = 3'd1,
        DRAIN    = 3'd2,
        SYNC     = 3'd3,
        TLBFL    = 3'd4,
        REDIRECT = 3'd5
    } flush_state_e;

    typedef enum logic [1:0] {
        REQ_EXC    = 2'd0,
        REQ_FENCE  = 2'd1,
        REQ_SFENCE = 2'd2
    } flush_req_e;

endpackage : control_pkg

// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Core-wide types shared by the pipeline, MMU and cache controllers.
//   XLEN          : architectural register / PC width
//   except_code_t : exception cause code
//   asid_t        : address-space identifier
//   vpn_t         : virtual page number
//   tlb_flush_e   : TLB flush scope requested by sfence.vma
// -----------------------------------------------------------------------------
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [3:0]  except_code_t;
    typedef logic [8:0]  asid_t;
    typedef logic [19:0] vpn_t;

    typedef enum logic [1:0] {
        NoFlush   = 2'd0,
        FlushAll  = 2'd1,
        FlushASID = 2'd2,
        FlushPage = 2'd3
    } tlb_flush_e;

endpackage : riscv_pkg

// File: rtl/flush_seq_timer.sv
// -----------------------------------------------------------------------------
// flush_seq_timer
// Loadable down-counter with a zero flag. Load has priority over decrement;
// the count saturates at zero.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   load_i         : load load_val_i this cycle
//   load_val_i     : value to load
//   dec_i          : decrement by one (ignored while zero)
//   zero_o         : count is zero
// -----------------------------------------------------------------------------
module flush_seq_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule : flush_seq_timer

// File: rtl/flush_seq_ctrl.sv
// -----------------------------------------------------------------------------
// flush_seq_ctrl
// Sequences pipeline flushes for exceptions, fence (D$->L2 sync) and
// sfence.vma (TLB flush), then issues a one-cycle PC redirect.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for exception / fence / sfence
//   ABORT    | flush+abort+MSHR clears held for FLUSH_CYCLES cycles
//   DRAIN    | wait for DTLB and L1D to accept LSQ requests
//   SYNC     | fence: request L1D->L2 writeback, wait for done or timeout
//   TLBFL    | sfence: one-cycle L1/L2 TLB flush with latched fields
//   REDIRECT | one-cycle redirect; a pending exception diverts to ABORT
//
// Ports
//   clk_i, rst_n_i                 : clock, asynchronous active-low reset
//   except_raised_i/code_i, tvec_i : exception request, cause, trap vector
//   fence_i, sfence_i, sfence_*_i  : fence / sfence requests and fields
//   pc_i                           : PC of the fence instruction
//   main_cu_stall_i                : stall from the main control unit
//   dtlb/l1dc_lsq_req_rdy_i        : drain readiness
//   l2c_update_done_i              : L2 sync completion
//   flush_o, abort_o, clr_*_o      : pipeline / MSHR clear strobes
//   synch_l1dc_l2c_o               : L1D->L2 sync request
//   L1/L2TLB_flush_type_o, flush_* : TLB flush command
//   stall_o, busy_o                : stall to front-end, sequencer active
//   redirect_valid_o/pc_o, cause_o : redirect and last accepted cause
//   timeout_o                      : sticky SYNC timeout flag
// -----------------------------------------------------------------------------
module flush_seq_ctrl
    import riscv_pkg::*;
    import control_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int unsigned SYNC_TIMEOUT = SYNC_TIMEOUT_DEF
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            except_raised_i,
    input  except_code_t    except_code_i,
    input  logic [XLEN-1:0] tvec_i,
    input  logic            fence_i,
    input  logic            sfence_i,
    input  tlb_flush_e      sfence_type_i,
    input  asid_t           sfence_asid_i,
    input  vpn_t            sfence_page_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            main_cu_stall_i,
    input  logic            dtlb_lsq_req_rdy_i,
    input  logic            l1dc_lsq_req_rdy_i,
    input  logic            l2c_update_done_i,
    output logic            flush_o,
    output logic            abort_o,
    output logic            clr_l1tlb_mshr_o,
    output logic            clr_l2tlb_mshr_o,
    output logic            clear_dmshr_dregs_o,
    output logic            synch_l1dc_l2c_o,
    output tlb_flush_e      L1TLB_flush_type_o,
    output tlb_flush_e      L2TLB_flush_type_o,
    output asid_t           flush_asid_o,
    output vpn_t            flush_page_o,
    output logic            stall_o,
    output logic            busy_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output except_code_t    cause_o,
    output logic            timeout_o
);

    localparam logic [FLUSH_CNT_W-1:0] ABORT_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [SYNC_CNT_W-1:0]  SYNC_LOAD  = SYNC_CNT_W'(SYNC_TIMEOUT - 1);

    flush_state_e    state_q, state_d;
    flush_req_e      req_q;
    logic [XLEN-1:0] tgt_pc_q;
    except_code_t    cause_q;
    tlb_flush_e      sf_type_q;
    asid_t           sf_asid_q;
    vpn_t            sf_page_q;
    logic            pend_q;
    except_code_t    pend_cause_q;
    logic [XLEN-1:0] pend_tvec_q;
    logic            timeout_q;

    logic            abort_zero, sync_zero;
    logic            abort_load, sync_load;
    logic            take_pend, exc_while_busy, sync_expire, drained;
    logic [XLEN-1:0] fence_next_pc;

    assign fence_next_pc  = pc_i + XLEN'(4);
    assign drained        = dtlb_lsq_req_rdy_i && l1dc_lsq_req_rdy_i;
    // An exception seen in REDIRECT itself is taken there directly
    assign take_pend      = (state_q == REDIRECT) && (pend_q || except_raised_i);
    assign exc_while_busy = except_raised_i && (state_q != IDLE) && (state_q != ABORT);
    // done on the last allowed cycle still counts as success
    assign sync_expire    = (state_q == SYNC) && !l2c_update_done_i && sync_zero;

    assign abort_load = (state_d == ABORT) && (state_q != ABORT);
    assign sync_load  = (state_q == DRAIN) && (state_d == SYNC);

    flush_seq_timer #(.WIDTH(FLUSH_CNT_W)) u_abort_timer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (abort_load),
        .load_val_i (ABORT_LOAD),
        .dec_i      (state_q == ABORT),
        .zero_o     (abort_zero)
    );

    flush_seq_timer #(.WIDTH(SYNC_CNT_W)) u_sync_timer (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .load_i     (sync_load),
        .load_val_i (SYNC_LOAD),
        .dec_i      (state_q == SYNC),
        .zero_o     (sync_zero)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (except_raised_i) begin
                    state_d = ABORT;
                end else if (fence_i || sfence_i) begin
                    state_d = DRAIN;
                end
            end
            ABORT: begin
                if (abort_zero) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drained) begin
                    unique case (req_q)
                        REQ_FENCE:  state_d = SYNC;
                        REQ_SFENCE: state_d = TLBFL;
                        default:    state_d = REDIRECT;
                    endcase
                end
            end
            SYNC: begin
                if (l2c_update_done_i || sync_zero) begin
                    state_d = REDIRECT;
                end
            end
            TLBFL:    state_d = REDIRECT;
            REDIRECT: state_d = take_pend ? ABORT : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            req_q        <= REQ_EXC;
            tgt_pc_q     <= '0;
            cause_q      <= '0;
            sf_type_q    <= NoFlush;
            sf_asid_q    <= '0;
            sf_page_q    <= '0;
            pend_q       <= 1'b0;
            pend_cause_q <= '0;
            pend_tvec_q  <= '0;
            timeout_q    <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (except_raised_i) begin
                    req_q    <= REQ_EXC;
                    tgt_pc_q <= tvec_i;
                    cause_q  <= except_code_i;
                end else if (fence_i) begin
                    req_q    <= REQ_FENCE;
                    tgt_pc_q <= fence_next_pc;
                end else if (sfence_i) begin
                    req_q     <= REQ_SFENCE;
                    tgt_pc_q  <= fence_next_pc;
                    sf_type_q <= sfence_type_i;
                    sf_asid_q <= sfence_asid_i;
                    sf_page_q <= sfence_page_i;
                end
            end

            if (take_pend) begin
                req_q  <= REQ_EXC;
                pend_q <= 1'b0;
                if (pend_q) begin
                    tgt_pc_q <= pend_tvec_q;
                    cause_q  <= pend_cause_q;
                end else begin
                    tgt_pc_q <= tvec_i;
                    cause_q  <= except_code_i;
                end
            end else if (exc_while_busy && !pend_q) begin
                pend_q       <= 1'b1;
                pend_cause_q <= except_code_i;
                pend_tvec_q  <= tvec_i;
            end

            if (sync_expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        flush_o             = (state_q == ABORT);
        abort_o             = (state_q == ABORT);
        clr_l1tlb_mshr_o    = (state_q == ABORT);
        clr_l2tlb_mshr_o    = (state_q == ABORT);
        clear_dmshr_dregs_o = (state_q == ABORT);
        synch_l1dc_l2c_o    = (state_q == SYNC);
        L1TLB_flush_type_o  = NoFlush;
        L2TLB_flush_type_o  = NoFlush;
        flush_asid_o        = '0;
        flush_page_o        = '0;
        if (state_q == TLBFL) begin
            L1TLB_flush_type_o = sf_type_q;
            L2TLB_flush_type_o = sf_type_q;
            flush_asid_o       = sf_asid_q;
            flush_page_o       = sf_page_q;
        end
    end

    assign busy_o           = (state_q != IDLE);
    assign stall_o          = main_cu_stall_i || busy_o;
    assign redirect_valid_o = (state_q == REDIRECT) && !take_pend;
    assign redirect_pc_o    = tgt_pc_q;
    assign cause_o          = cause_q;
    assign timeout_o        = timeout_q;

endmodule : flush_seq_ctrl

// File: tb/tb_flush_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_flush_seq_ctrl
// Directed stimulus pushes the expected redirect (plus the strobe cycle counts
// that should precede it) into a queue; a monitor at the falling edge
// accumulates what the DUT does and compares on each visible redirect.
// -----------------------------------------------------------------------------
module tb_flush_seq_ctrl;
    import riscv_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            except_raised;
    except_code_t    except_code;
    logic [XLEN-1:0] tvec;
    logic            fence, sfence;
    tlb_flush_e      sfence_type;
    asid_t           sfence_asid;
    vpn_t            sfence_page;
    logic [XLEN-1:0] pc;
    logic            main_stall, dtlb_rdy, l1dc_rdy, l2c_done;

    logic            flush_o, abort_o, clr_l1, clr_l2, clr_d, synch;
    tlb_flush_e      l1_type, l2_type;
    asid_t           flush_asid;
    vpn_t            flush_page;
    logic            stall_o, busy_o, redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    except_code_t    cause_o;
    logic            timeout_o;

    always #5 clk = ~clk;

    flush_seq_ctrl #(.FLUSH_CYCLES(2), .SYNC_TIMEOUT(16)) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .except_raised_i     (except_raised),
        .except_code_i       (except_code),
        .tvec_i              (tvec),
        .fence_i             (fence),
        .sfence_i            (sfence),
        .sfence_type_i       (sfence_type),
        .sfence_asid_i       (sfence_asid),
        .sfence_page_i       (sfence_page),
        .pc_i                (pc),
        .main_cu_stall_i     (main_stall),
        .dtlb_lsq_req_rdy_i  (dtlb_rdy),
        .l1dc_lsq_req_rdy_i  (l1dc_rdy),
        .l2c_update_done_i   (l2c_done),
        .flush_o             (flush_o),
        .abort_o             (abort_o),
        .clr_l1tlb_mshr_o    (clr_l1),
        .clr_l2tlb_mshr_o    (clr_l2),
        .clear_dmshr_dregs_o (clr_d),
        .synch_l1dc_l2c_o    (synch),
        .L1TLB_flush_type_o  (l1_type),
        .L2TLB_flush_type_o  (l2_type),
        .flush_asid_o        (flush_asid),
        .flush_page_o        (flush_page),
        .stall_o             (stall_o),
        .busy_o              (busy_o),
        .redirect_valid_o    (redirect_valid),
        .redirect_pc_o       (redirect_pc),
        .cause_o             (cause_o),
        .timeout_o           (timeout_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  cause;
        int          flush;
        int          synch;
        int          busy;
        int          tlb;
        tlb_flush_e  tlb_type;
        logic [8:0]  asid;
        logic [19:0] page;
        logic        timeout;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] p, input logic [3:0] c, input int fl,
                            input int sy, input int bz, input int tl, input tlb_flush_e ty,
                            input logic [8:0] a, input logic [19:0] pg, input logic to);
        exp_t e;
        e.pc = p; e.cause = c; e.flush = fl; e.synch = sy; e.busy = bz;
        e.tlb = tl; e.tlb_type = ty; e.asid = a; e.page = pg; e.timeout = to;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    int         m_busy, m_flush, m_flush_bad, m_synch, m_tlb;
    tlb_flush_e m_l1, m_l2;
    logic [8:0] m_asid;
    logic [19:0] m_page;

    task automatic mon_clear();
        m_busy = 0; m_flush = 0; m_flush_bad = 0; m_synch = 0; m_tlb = 0;
        m_l1 = NoFlush; m_l2 = NoFlush; m_asid = '0; m_page = '0;
    endtask

    initial mon_clear();

    always @(negedge clk) begin
        logic [4:0] grp;
        exp_t e;
        if (!rst_n) begin
            mon_clear();
        end else begin
            if (busy_o) m_busy++;
            grp = {flush_o, abort_o, clr_l1, clr_l2, clr_d};
            if (grp == 5'b11111) m_flush++;
            else if (grp != 5'b00000) m_flush_bad++;
            if (synch) m_synch++;
            if (l1_type != NoFlush) begin
                m_tlb++; m_l1 = l1_type; m_l2 = l2_type; m_asid = flush_asid; m_page = flush_page;
            end
            if (redirect_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL redirect_unexpected: got redirect to 0x%0h, required none", redirect_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("redirect_pc",    redirect_pc, e.pc);
                    chk("cause",          cause_o,     e.cause);
                    chk("timeout",        timeout_o,   e.timeout);
                    chk("flush_cycles",   m_flush,     e.flush);
                    chk("flush_group",    m_flush_bad, 0);
                    chk("synch_cycles",   m_synch,     e.synch);
                    chk("busy_cycles",    m_busy,      e.busy);
                    chk("tlbfl_cycles",   m_tlb,       e.tlb);
                    chk("l1tlb_type",     m_l1,        e.tlb_type);
                    chk("l2tlb_type",     m_l2,        e.tlb_type);
                    chk("flush_asid",     m_asid,      e.asid);
                    chk("flush_page",     m_page,      e.page);
                end
                mon_clear();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy_o) break;
        end
        chk(tag, busy_o, 0);
    endtask

    task automatic wait_synch(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (synch) break;
        end
        chk(tag, synch, 1);
    endtask

    task automatic check_reset_vals(input logic exp_stall);
        chk("rst_flush",    flush_o,        0);
        chk("rst_abort",    abort_o,        0);
        chk("rst_clr_l1",   clr_l1,         0);
        chk("rst_clr_l2",   clr_l2,         0);
        chk("rst_clr_d",    clr_d,          0);
        chk("rst_synch",    synch,          0);
        chk("rst_l1_type",  l1_type,        NoFlush);
        chk("rst_l2_type",  l2_type,        NoFlush);
        chk("rst_asid",     flush_asid,     0);
        chk("rst_page",     flush_page,     0);
        chk("rst_stall",    stall_o,        exp_stall);
        chk("rst_busy",     busy_o,         0);
        chk("rst_redir_v",  redirect_valid, 0);
        chk("rst_redir_pc", redirect_pc,    0);
        chk("rst_cause",    cause_o,        0);
        chk("rst_timeout",  timeout_o,      0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        except_raised = 0; except_code = '0; tvec = '0;
        fence = 0; sfence = 0; sfence_type = NoFlush; sfence_asid = '0; sfence_page = '0;
        pc = '0; main_stall = 0; dtlb_rdy = 1; l1dc_rdy = 1; l2c_done = 0;

        #2;
        check_reset_vals(1'b0);
        main_stall = 1;
        #1;
        chk("rst_stall_follow", stall_o, 1);
        main_stall = 0;
        step(); step();
        rst_n = 1'b1;
        step();

        // Exception; a second exception while in ABORT must be dropped
        except_raised = 1; except_code = 4'd5; tvec = 32'h8000_0100;
        push_exp(32'h8000_0100, 4'd5, 2, 0, 4, 0, NoFlush, 9'd0, 20'd0, 1'b0);
        step();
        except_code = 4'd9; tvec = 32'h8000_0900;
        @(negedge clk);
        chk("stall_while_busy", stall_o, 1);
        step();
        except_raised = 0;
        wait_idle(20, "exc_idle");

        // fence: done arrives on the 8th SYNC cycle
        step();
        fence = 1; pc = 32'h0000_1000;
        push_exp(32'h0000_1004, 4'd5, 0, 8, 10, 0, NoFlush, 9'd0, 20'd0, 1'b0);
        step();
        fence = 0;
        wait_synch(10, "fence_synch_start");
        repeat (7) @(posedge clk);
        #1 l2c_done = 1;
        step();
        l2c_done = 0;
        wait_idle(20, "fence_idle");

        // sfence ASID with 4 not-ready drain cycles; pc_i+4 wraps to 0
        step();
        sfence = 1; sfence_type = FlushASID; sfence_asid = 9'd3; sfence_page = 20'h12345;
        pc = 32'hFFFF_FFFC; l1dc_rdy = 0;
        push_exp(32'h0000_0000, 4'd5, 0, 0, 7, 1, FlushASID, 9'd3, 20'h12345, 1'b0);
        step();
        sfence = 0; sfence_type = NoFlush; sfence_asid = '0; sfence_page = '0;
        repeat (4) step();
        l1dc_rdy = 1;
        wait_idle(20, "sfence_idle");

        // exception during fence SYNC: fence redirect suppressed, goes to ABORT
        step();
        fence = 1; pc = 32'h0000_2000;
        push_exp(32'h8000_0200, 4'd7, 2, 6, 12, 0, NoFlush, 9'd0, 20'd0, 1'b0);
        step();
        fence = 0;
        wait_synch(10, "nest_synch_start");
        repeat (3) @(posedge clk);
        #1 except_raised = 1; except_code = 4'd7; tvec = 32'h8000_0200;
        step();
        except_raised = 0;
        step();
        l2c_done = 1;
        step();
        l2c_done = 0;
        wait_idle(30, "nest_idle");

        // fence with no done: SYNC times out after 16 cycles
        step();
        fence = 1; pc = 32'h0000_3000;
        push_exp(32'h0000_3004, 4'd7, 0, 16, 18, 0, NoFlush, 9'd0, 20'd0, 1'b1);
        step();
        fence = 0;
        wait_idle(40, "timeout_idle");

        // reset in the middle of ABORT, no clock edge before checking
        step();
        main_stall = 1;
        except_raised = 1; except_code = 4'd3; tvec = 32'h8000_0300;
        step();
        except_raised = 0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals(1'b1);
        step(); step();
        rst_n = 1'b1; main_stall = 0;
        step();
        except_raised = 1; except_code = 4'd4; tvec = 32'h8000_0400;
        push_exp(32'h8000_0400, 4'd4, 2, 0, 4, 0, NoFlush, 9'd0, 20'd0, 1'b0);
        step();
        except_raised = 0;
        wait_idle(20, "post_reset_idle");

        repeat (3) step();
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_flush_seq_ctrl
